// File: rtl/auc_pkg.sv
// Shared definitions for the AUC command path: mode codes, operand counts,
// response codes and the scheduler state encoding. The host and the decoder
// use the same mode codes.
package auc_pkg;

    typedef enum logic [2:0] {
        MODE_RAND = 3'd0,
        MODE_INVS = 3'd1,
        MODE_R    = 3'd2,
        MODE_S    = 3'd3,
        MODE_WMUL = 3'd4,
        MODE_MMUL = 3'd5
    } mode_e;

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_ILLEGAL = 2'b01,
        RSP_TIMEOUT = 2'b10
    } rsp_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_BURST = 3'd2,
        ST_GAP   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

    // Largest operand set (WMUL) and the pointer width that addresses it
    localparam int OPBUF_SLOTS = 5;
    localparam int PTR_W       = 3;

    // Codes 6 and 7 are not decoder operations
    function automatic logic mode_legal(input logic [2:0] mode);
        return (mode <= MODE_MMUL);
    endfunction

    // Number of operand words the host sends for a mode
    function automatic logic [2:0] op_count(input logic [2:0] mode);
        case (mode)
            MODE_S:    return 3'd2;   // HASH, PKEY
            MODE_MMUL: return 3'd4;   // ZR, ONE, XG, K
            MODE_WMUL: return 3'd5;   // ZR, ONE, XG, YG, K
            default:   return 3'd0;   // RAND, INVS, R (and illegal codes)
        endcase
    endfunction

endpackage

// File: rtl/auc_opbuf.sv
// Operand buffer: one register per slot, synchronous write, combinational read.
// Slots clear on reset so an unwritten slot always reads as zero.
module auc_opbuf
    import auc_pkg::*;
#(
    parameter int WIDTH    = 256,
    parameter int SLOTS    = OPBUF_SLOTS,
    parameter int BUF_PTRW = PTR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [BUF_PTRW-1:0] wptr,
    input  logic [WIDTH-1:0]    wdat,
    input  logic [BUF_PTRW-1:0] rptr,
    output logic [WIDTH-1:0]    rdat
);

    logic [SLOTS-1:0][WIDTH-1:0] slot_dat;

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic [WIDTH-1:0] data_reg;

            // Load this slot when it is the write target
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= '0;
                end else if (we && (wptr == BUF_PTRW'(gi))) begin
                    data_reg <= wdat;
                end
            end

            assign slot_dat[gi] = data_reg;
        end
    endgenerate

    // Read mux; a pointer past the last slot reads as zero
    always_comb begin
        rdat = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (rptr == BUF_PTRW'(i)) begin
                rdat = slot_dat[i];
            end
        end
    end

endmodule

// File: rtl/auc_cmd_sched.sv
// Command scheduler in front of the AUC decoder: accepts a mode and its
// operands, replays them as one unbroken auc_start burst, then waits for
// core_done or the watchdog and returns a one-cycle response.
// Every output is registered from the next-state value, so each output
// reflects the state the FSM occupies in that cycle.
module auc_cmd_sched
    import auc_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int TMO   = 65535,
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_dat,
    output logic [WIDTH-1:0] auc_dat,
    output logic             auc_start,
    output logic [2:0]       auc_mode,
    input  logic             core_done,
    output logic             busy,
    output logic             rsp_valid,
    output logic [1:0]       rsp_err
);

    state_e             state_reg, state_next;
    logic [PTR_W-1:0]   wptr_reg, wptr_next;
    logic [PTR_W-1:0]   rptr_reg, rptr_next;
    logic               gap_reg, gap_next;
    logic [TMO_W-1:0]   wdog_reg, wdog_next;
    rsp_e               rsp_code;

    logic               cmd_ready_reg, cmd_ready_next;
    logic               wr_ready_reg, wr_ready_next;
    logic               auc_start_reg, auc_start_next;
    logic [WIDTH-1:0]   auc_dat_reg, auc_dat_next;
    logic [2:0]         auc_mode_reg, auc_mode_next;
    logic               busy_reg, busy_next;
    logic               rsp_valid_reg, rsp_valid_next;
    logic [1:0]         rsp_err_reg, rsp_err_next;

    logic [2:0]         mode_cur;
    logic [2:0]         n_cur;
    logic [PTR_W-1:0]   last_idx;
    logic               cmd_fire;
    logic               wr_fire;
    logic [WIDTH-1:0]   buf_rdat;

    // In IDLE the mode being offered is still on the command bus
    assign mode_cur = (state_reg == ST_IDLE) ? cmd_mode : auc_mode_reg;
    assign n_cur    = op_count(mode_cur);
    assign last_idx = (n_cur == 3'd0) ? '0 : (n_cur - 3'd1);
    assign cmd_fire = (state_reg == ST_IDLE) && cmd_valid && cmd_ready_reg;
    assign wr_fire  = (state_reg == ST_LOAD) && wr_valid && wr_ready_reg;

    // Read side follows rptr_next so the registered auc_dat lines up with the burst
    auc_opbuf #(
        .WIDTH    (WIDTH),
        .SLOTS    (OPBUF_SLOTS),
        .BUF_PTRW (PTR_W)
    ) u_opbuf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_fire),
        .wptr  (wptr_reg),
        .wdat  (wr_dat),
        .rptr  (rptr_next),
        .rdat  (buf_rdat)
    );

    // State, pointers and watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            gap_reg   <= 1'b0;
            wdog_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            gap_reg   <= gap_next;
            wdog_reg  <= wdog_next;
        end
    end

    // Next-state logic; rsp_code carries the reason whenever RESP is entered
    always_comb begin
        state_next = state_reg;
        wptr_next  = wptr_reg;
        rptr_next  = rptr_reg;
        gap_next   = gap_reg;
        wdog_next  = wdog_reg;
        rsp_code   = RSP_OK;
        case (state_reg)
            ST_IDLE: begin
                wptr_next = '0;
                rptr_next = '0;
                if (cmd_fire) begin
                    if (!mode_legal(cmd_mode)) begin
                        state_next = ST_RESP;
                        rsp_code   = RSP_ILLEGAL;
                    end else if (n_cur == 3'd0) begin
                        state_next = ST_BURST;
                    end else begin
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (wr_fire) begin
                    wptr_next = wptr_reg + 1'b1;
                    if (wptr_reg == last_idx) begin
                        state_next = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (rptr_reg == last_idx) begin
                    state_next = ST_GAP;
                    gap_next   = 1'b0;
                end else begin
                    rptr_next = rptr_reg + 1'b1;
                end
            end
            ST_GAP: begin
                // Two idle cycles cover the decoder's start pipeline
                if (gap_reg) begin
                    state_next = ST_WAIT;
                    wdog_next  = '0;
                end else begin
                    gap_next = 1'b1;
                end
            end
            ST_WAIT: begin
                // core_done is checked first so it wins on the final watchdog cycle
                if (core_done) begin
                    state_next = ST_RESP;
                    rsp_code   = RSP_OK;
                end else if (wdog_reg == TMO_W'(TMO - 1)) begin
                    state_next = ST_RESP;
                    rsp_code   = RSP_TIMEOUT;
                end else begin
                    wdog_next = wdog_reg + 1'b1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output values for the state being entered
    always_comb begin
        cmd_ready_next = (state_next == ST_IDLE);
        wr_ready_next  = (state_next == ST_LOAD);
        auc_start_next = (state_next == ST_BURST);
        busy_next      = (state_next != ST_IDLE);
        rsp_valid_next = (state_next == ST_RESP);
        rsp_err_next   = (state_next == ST_RESP) ? rsp_code : RSP_OK;
        auc_mode_next  = (state_next == ST_IDLE) ? 3'd0 : mode_cur;
        // Zero-operand modes send a single zero word regardless of stale buffer contents
        auc_dat_next   = '0;
        if ((state_next == ST_BURST) && (n_cur != 3'd0)) begin
            auc_dat_next = buf_rdat;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_reg <= 1'b0;
            wr_ready_reg  <= 1'b0;
            auc_start_reg <= 1'b0;
            auc_dat_reg   <= '0;
            auc_mode_reg  <= 3'd0;
            busy_reg      <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 2'b00;
        end else begin
            cmd_ready_reg <= cmd_ready_next;
            wr_ready_reg  <= wr_ready_next;
            auc_start_reg <= auc_start_next;
            auc_dat_reg   <= auc_dat_next;
            auc_mode_reg  <= auc_mode_next;
            busy_reg      <= busy_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign wr_ready  = wr_ready_reg;
    assign auc_start = auc_start_reg;
    assign auc_dat   = auc_dat_reg;
    assign auc_mode  = auc_mode_reg;
    assign busy      = busy_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_auc_cmd_sched.sv
// Directed bench for auc_cmd_sched. Two instances share all inputs: dut uses
// a long watchdog (TMO_A) and dut_b uses TMO_B = 8 for the timeout cases.
// Expected burst words and response codes are queued when a command is
// driven and popped by the negedge monitor when the DUT produces them.
module tb_auc_cmd_sched;

    localparam int W     = 64;
    localparam int TMO_A = 20;
    localparam int TMO_B = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [2:0]   cmd_mode = 3'd0;
    logic         wr_valid = 1'b0;
    logic [W-1:0] wr_dat = '0;
    logic         core_done = 1'b0;

    logic         cmd_ready, wr_ready, auc_start, busy, rsp_valid;
    logic [W-1:0] auc_dat;
    logic [2:0]   auc_mode;
    logic [1:0]   rsp_err;

    logic         cmd_ready_b, wr_ready_b, auc_start_b, busy_b, rsp_valid_b;
    logic [W-1:0] auc_dat_b;
    logic [2:0]   auc_mode_b;
    logic [1:0]   rsp_err_b;

    auc_cmd_sched #(.WIDTH(W), .TMO(TMO_A), .TMO_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dat(wr_dat),
        .auc_dat(auc_dat), .auc_start(auc_start), .auc_mode(auc_mode),
        .core_done(core_done), .busy(busy), .rsp_valid(rsp_valid), .rsp_err(rsp_err)
    );

    auc_cmd_sched #(.WIDTH(W), .TMO(TMO_B), .TMO_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
        .cmd_mode(cmd_mode), .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_dat(wr_dat),
        .auc_dat(auc_dat_b), .auc_start(auc_start_b), .auc_mode(auc_mode_b),
        .core_done(core_done), .busy(busy_b), .rsp_valid(rsp_valid_b), .rsp_err(rsp_err_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_dat[$];
    logic [1:0]   exp_rsp[$];
    logic [1:0]   exp_rsp_b[$];
    logic [W-1:0] words [0:4];
    logic [2:0]   cur_mode = 3'd0;

    int  b_cyc = -1;
    int  rsp_cyc = -1;
    int  rsp_b_cyc = -1;
    int  n_runs = 0;
    int  n_wr_acc = 0;
    bit  prev_start = 1'b0;

    function automatic void chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT emits a burst word or response
    always @(negedge clk) begin
        if (rst_n) begin
            if (auc_start) begin
                if (!prev_start) begin
                    b_cyc = cyc;
                    n_runs++;
                end
                if (exp_dat.size() == 0) chk("burst_extra_word", 1, 0);
                else chk("auc_dat", auc_dat, exp_dat.pop_front());
                chk("auc_mode_burst", W'(auc_mode), W'(cur_mode));
            end else begin
                chk("auc_dat_zero_when_idle", auc_dat, '0);
            end
            if (wr_valid && wr_ready) n_wr_acc++;
            if (rsp_valid) begin
                rsp_cyc = cyc;
                if (exp_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
                else chk("rsp_err", W'(rsp_err), W'(exp_rsp.pop_front()));
                chk("auc_mode_rsp", W'(auc_mode), W'(cur_mode));
            end
            if (rsp_valid_b) begin
                rsp_b_cyc = cyc;
                if (exp_rsp_b.size() == 0) chk("rsp_b_unexpected", 1, 0);
                else chk("rsp_err_b", W'(rsp_err_b), W'(exp_rsp_b.pop_front()));
            end
        end
        prev_start = auc_start && rst_n;
    end

    // Handshake the command and feed n words following the wr_valid pattern vpat
    task automatic handshake_load(input logic [2:0] mode, input int n, input logic [7:0] vpat,
                                  input bit hold_wr, output int acc_cyc, output int last_acc);
        int guard;
        int idx;
        wr_valid  = hold_wr;
        cmd_mode  = mode;
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            tick();
            guard++;
        end
        chk("cmd_ready_wait", W'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        cmd_mode  = 3'd0;
        acc_cyc   = cyc;
        last_acc  = acc_cyc - 1;
        if (n > 0) begin
            idx = 0;
            guard = 0;
            while (idx < n && guard < 64) begin
                wr_valid = (guard < 8) ? vpat[guard] : 1'b1;
                wr_dat   = words[idx];
                chk("wr_ready_in_load", W'(wr_ready), 1);
                if (wr_valid) begin
                    idx++;
                    last_acc = cyc;
                end
                tick();
                guard++;
            end
            wr_valid = hold_wr;
            wr_dat   = 'hDEAD;
        end
    endtask

    // One full command; k = WAIT cycle carrying core_done (-1 never), ghost = extra pulse in last GAP cycle
    task automatic run_cmd(input logic [2:0] mode, input int n, input logic [7:0] vpat,
                           input bit hold_wr, input int k, input bit ghost);
        int  acc_cyc, last_acc, b_exp, l, rsp_a_exp, rsp_b_exp, end_cyc, runs0, acc0;
        bit  legal;
        legal = (mode <= 3'd5);
        l = (n == 0) ? 1 : n;
        cur_mode = mode;
        b_cyc = -1;
        rsp_cyc = -1;
        rsp_b_cyc = -1;
        runs0 = n_runs;
        acc0  = n_wr_acc;
        if (legal) begin
            for (int i = 0; i < l; i++) exp_dat.push_back((n == 0) ? '0 : words[i]);
            exp_rsp.push_back((k >= 0 && k < TMO_A) ? 2'b00 : 2'b10);
            exp_rsp_b.push_back((k >= 0 && k < TMO_B) ? 2'b00 : 2'b10);
        end else begin
            exp_rsp.push_back(2'b01);
            exp_rsp_b.push_back(2'b01);
        end
        handshake_load(mode, legal ? n : 0, vpat, hold_wr, acc_cyc, last_acc);
        b_exp = last_acc + 1;
        if (legal) begin
            rsp_a_exp = b_exp + l + 2 + ((k >= 0 && k < TMO_A) ? k : TMO_A - 1) + 1;
            rsp_b_exp = b_exp + l + 2 + ((k >= 0 && k < TMO_B) ? k : TMO_B - 1) + 1;
        end else begin
            rsp_a_exp = acc_cyc;
            rsp_b_exp = acc_cyc;
        end
        end_cyc = ((rsp_a_exp > rsp_b_exp) ? rsp_a_exp : rsp_b_exp) + 1;
        while (cyc < end_cyc) begin
            core_done = legal && ((ghost && cyc == b_exp + l + 1) || (k >= 0 && cyc == b_exp + l + 2 + k));
            tick();
        end
        core_done = 1'b0;
        wr_valid  = 1'b0;
        chk("cmd_ready_after_rsp", W'(cmd_ready), 1);
        chk("busy_after_rsp", W'(busy), 0);
        chk("rsp_cycle", W'(rsp_cyc), W'(rsp_a_exp));
        chk("rsp_b_cycle", W'(rsp_b_cyc), W'(rsp_b_exp));
        chk("burst_runs", W'(n_runs - runs0), legal ? 1 : 0);
        chk("burst_words_left", W'(exp_dat.size()), 0);
        chk("words_accepted", W'(n_wr_acc - acc0), legal ? W'(n) : 0);
        if (legal) chk("burst_start_cycle", W'(b_cyc), W'(b_exp));
        $display("[TB] cmd mode=%0d n=%0d acc=%0d b=%0d rsp=%0d rsp_b=%0d", mode, n, acc_cyc, b_cyc, rsp_cyc, rsp_b_cyc);
        exp_dat.delete();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int acc_cyc, last_acc, b_exp;
        for (int i = 0; i < 5; i++) words[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", W'(cmd_ready), 0);
        chk("rst_wr_ready", W'(wr_ready), 0);
        chk("rst_auc_start", W'(auc_start), 0);
        chk("rst_auc_dat", auc_dat, '0);
        chk("rst_auc_mode", W'(auc_mode), 0);
        chk("rst_busy", W'(busy), 0);
        chk("rst_rsp_valid", W'(rsp_valid), 0);
        chk("rst_rsp_err", W'(rsp_err), 0);
        rst_n = 1'b1;
        chk("cmd_ready_before_edge", W'(cmd_ready), 0);
        tick();
        chk("cmd_ready_first_edge", W'(cmd_ready), 1);

        // WMUL, done 10 cycles into WAIT (dut_b times out first)
        words[0] = 'h0; words[1] = 'h1; words[2] = 'hA1; words[3] = 'hB2; words[4] = 'h5;
        run_cmd(3'd4, 5, 8'hFF, 1'b0, 10, 1'b0);

        // RAND with wr_valid held; a core_done in the last GAP cycle must be ignored
        run_cmd(3'd0, 0, 8'hFF, 1'b1, 0, 1'b1);

        // S with wr_valid 1-0-0-1, then held high with a word that must stay pending
        words[0] = 'h11; words[1] = 'h22;
        run_cmd(3'd3, 2, 8'h09, 1'b1, 3, 1'b0);

        // Illegal modes
        run_cmd(3'd6, 0, 8'hFF, 1'b0, 0, 1'b0);
        run_cmd(3'd7, 0, 8'hFF, 1'b0, 0, 1'b0);

        // Timeout, then core_done on the last watchdog cycle of dut_b
        words[0] = 'h10; words[1] = 'h20; words[2] = 'h30; words[3] = 'h40;
        run_cmd(3'd5, 4, 8'hFF, 1'b0, -1, 1'b0);
        words[0] = 'h77; words[1] = 'h66; words[2] = 'h55; words[3] = 'h44;
        run_cmd(3'd5, 4, 8'h5B, 1'b0, TMO_B - 1, 1'b0);

        // Remaining zero-operand modes; dummy word must be zero despite stale buffer
        run_cmd(3'd1, 0, 8'hFF, 1'b0, 2, 1'b0);
        run_cmd(3'd2, 0, 8'hFF, 1'b0, 0, 1'b0);

        // Reset in the 3rd burst cycle of a WMUL
        words[0] = 'hC0; words[1] = 'hC1; words[2] = 'hC2; words[3] = 'hC3; words[4] = 'hC4;
        cur_mode = 3'd4;
        rsp_cyc = -1;
        rsp_b_cyc = -1;
        for (int i = 0; i < 5; i++) exp_dat.push_back(words[i]);
        handshake_load(3'd4, 5, 8'hFF, 1'b0, acc_cyc, last_acc);
        b_exp = last_acc + 1;
        while (cyc < b_exp + 2) tick();
        chk("burst_on_before_reset", W'(auc_start), 1);
        rst_n = 1'b0;
        #1;
        chk("reset_drops_auc_start", W'(auc_start), 0);
        chk("reset_drops_auc_start_b", W'(auc_start_b), 0);
        chk("reset_clears_busy", W'(busy), 0);
        chk("reset_clears_auc_mode", W'(auc_mode), 0);
        exp_dat.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("cmd_ready_before_edge_2", W'(cmd_ready), 0);
        tick();
        chk("cmd_ready_after_release", W'(cmd_ready), 1);
        for (int i = 0; i < 30; i++) begin
            core_done = (i == 12);
            tick();
        end
        core_done = 1'b0;
        chk("no_rsp_after_reset", W'(rsp_cyc), W'(-1));
        chk("no_rsp_b_after_reset", W'(rsp_b_cyc), W'(-1));
        $display("[TB] reset mid-burst b=%0d", b_exp);

        // A clean command still works after the reset
        words[0] = 'h1234; words[1] = 'h5678;
        run_cmd(3'd3, 2, 8'hFF, 1'b0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
